// File: rtl/pcie_tx_fifo_alloc.sv
`default_nettype none
// ============================================================================
// Module      : pcie_tx_fifo_alloc
// Description : Allocation-based TX data FIFO between the AXI read master
//               (DRAM->PCIe DMA read engine) and the PCIe TX packet builder.
//               The writer reserves space in 64 B units (8 x 64-bit words)
//               before issuing an AXI burst and then streams 64-bit beats.
//               The reader pops 128-bit entries (two words per pop).
//               full_n tracks *reserved* space, so a granted burst can never
//               overflow the storage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   m_axi_aclk              in   1    clock, rising edge
//   m_axi_aresetn           in   1    asynchronous active-low reset
//   pcie_tx_fifo_alloc_en   in   1    reserve space (one-cycle pulse)
//   pcie_tx_fifo_alloc_len  in   5    reservation size in 64 B units (0..16)
//   pcie_tx_fifo_wr_en      in   1    write one 64-bit beat
//   pcie_tx_fifo_wr_data    in   64   write beat
//   pcie_tx_fifo_full_n     out  1    1 = at least P_MAX_ALLOC words unreserved
//   tx_fifo_rd_en           in   1    pop one 128-bit entry
//   tx_fifo_rd_data         out  128  popped entry, valid 1 cycle after rd_en
//   tx_fifo_empty_n         out  1    1 = at least two written, unread words
//   tx_fifo_err             out  1    sticky overrun/underrun/over-allocation
// ============================================================================
module pcie_tx_fifo_alloc #(
    parameter int P_ADDR_WIDTH = 9,
    parameter int P_MAX_ALLOC  = 128
) (
    input  logic           m_axi_aclk,
    input  logic           m_axi_aresetn,
    input  logic           pcie_tx_fifo_alloc_en,
    input  logic [4:0]     pcie_tx_fifo_alloc_len,
    input  logic           pcie_tx_fifo_wr_en,
    input  logic [63:0]    pcie_tx_fifo_wr_data,
    output logic           pcie_tx_fifo_full_n,
    input  logic           tx_fifo_rd_en,
    output logic [127:0]   tx_fifo_rd_data,
    output logic           tx_fifo_empty_n,
    output logic           tx_fifo_err
);

    // Pointer width carries one extra wrap bit above the word address so
    // that a completely reserved FIFO is distinguishable from an empty one.
    localparam int              c_PW      = P_ADDR_WIDTH + 1;
    localparam int              c_DEPTH   = 1 << P_ADDR_WIDTH;
    localparam logic [c_PW:0]   c_DEPTH_W = c_DEPTH[c_PW:0];
    localparam logic [c_PW:0]   c_MAX_W   = P_MAX_ALLOC[c_PW:0];
    localparam logic [c_PW-1:0] c_TWO     = c_PW'(2);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PW-1:0]  alloc_ptr_q, alloc_ptr_d;
    logic [c_PW-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [c_PW-1:0]  rd_ptr_q,    rd_ptr_d;
    logic             full_n_q,    full_n_d;
    logic             empty_n_q,   empty_n_d;
    logic             err_q,       err_d;
    logic [127:0]     rd_data_q;

    logic [63:0]      mem_q [c_DEPTH];

    // ------------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------------
    logic [c_PW-1:0]         alloc_words;
    logic [c_PW-1:0]         reserved_now;
    logic                    alloc_over;
    logic                    wr_ok;
    logic                    wr_overrun;
    logic                    rd_ok;
    logic                    rd_underrun;
    logic [P_ADDR_WIDTH-1:0] wr_idx;
    logic [P_ADDR_WIDTH-1:0] rd_idx;
    logic [P_ADDR_WIDTH-1:0] rd_idx_hi;
    logic [c_PW-1:0]         occ_next;
    logic [c_PW:0]           free_next;
    logic [c_PW-1:0]         written_next;

    // One 64 B unit is eight 64-bit words.
    assign alloc_words  = c_PW'({pcie_tx_fifo_alloc_len, 3'b000});

    // Space currently held by reservations not yet drained by the reader.
    assign reserved_now = alloc_ptr_q - rd_ptr_q;

    // Over-allocation is flagged but the reservation is still applied; the
    // error is sticky, so the pointers are not trusted afterwards anyway.
    assign alloc_over   = pcie_tx_fifo_alloc_en &&
                          (({1'b0, reserved_now} + {1'b0, alloc_words}) > c_DEPTH_W);

    // A beat is only accepted inside reserved space.
    assign wr_ok        = pcie_tx_fifo_wr_en && (wr_ptr_q != alloc_ptr_q);
    assign wr_overrun   = pcie_tx_fifo_wr_en && (wr_ptr_q == alloc_ptr_q);

    // Reads are gated by the registered empty flag, which also guarantees the
    // two words being read are never the word being written this cycle.
    assign rd_ok        = tx_fifo_rd_en && empty_n_q;
    assign rd_underrun  = tx_fifo_rd_en && !empty_n_q;

    assign wr_idx       = wr_ptr_q[P_ADDR_WIDTH-1:0];
    assign rd_idx       = rd_ptr_q[P_ADDR_WIDTH-1:0];
    assign rd_idx_hi    = rd_idx + P_ADDR_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------------
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q;

        if (pcie_tx_fifo_alloc_en) begin
            alloc_ptr_d = alloc_ptr_q + alloc_words;
        end
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + c_PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + c_TWO;
        end

        if (alloc_over || wr_overrun || rd_underrun) begin
            err_d = 1'b1;
        end
    end

    // Flags are derived from the post-update pointers so that simultaneous
    // alloc, write and read in one cycle are all reflected together.
    assign occ_next     = alloc_ptr_d - rd_ptr_d;
    assign free_next    = c_DEPTH_W - {1'b0, occ_next};
    assign written_next = wr_ptr_d - rd_ptr_d;
    assign full_n_d     = (free_next >= c_MAX_W);
    assign empty_n_d    = (written_next >= c_TWO);

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            alloc_ptr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_n_q    <= 1'b1;
            empty_n_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_n_q    <= full_n_d;
            empty_n_q   <= empty_n_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: one 64-bit write port, one 128-bit (two-word) read port.
    // Contents are don't-care after reset, so the array carries no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge m_axi_aclk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= pcie_tx_fifo_wr_data;
        end
    end

    // Lower half of the entry is the earlier beat.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= {mem_q[rd_idx_hi], mem_q[rd_idx]};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pcie_tx_fifo_full_n = full_n_q;
    assign tx_fifo_empty_n     = empty_n_q;
    assign tx_fifo_err         = err_q;
    assign tx_fifo_rd_data     = rd_data_q;

endmodule
`default_nettype wire
